axo_mem_sram: RTL and testbench
===============================

AXO_MEM_SRAM -- requirements
Module: axo_mem_sram

Interface
REQ-001 SHALL have parameter dlen, default 32, bus data width; only 32 supported.
REQ-002 SHALL have parameter alen, default 32, bus address width.
REQ-003 SHALL have parameter awords, default 10, log2 of storage depth in dlen-bit words.
REQ-004 SHALL have parameter latency, default 1, wait states inserted before ready; range 0..15.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port bus, axo_mem_bus.MEM modport, dlen/alen, the responder end of the Axo memory bus.
REQ-008 SHALL have port wprot, input, 1, write-protect request; present only under AXO_MEM_SRAM_WPROT_EN.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT, RESP, defined in axo_mem_pkg.
REQ-010 In IDLE with re or we high at a rising edge: capture addr, asize, wdata, re, we; go to WAIT if latency>0, else RESP.
REQ-011 WAIT SHALL count latency cycles via a 4-bit down-counter, then go to RESP.
REQ-012 RESP SHALL drive ready=1 for exactly one cycle, then return to IDLE.
REQ-013 Total latency: ready SHALL be high in the (latency+1)th cycle after the request is sampled.
REQ-014 Outside RESP, ready=0, error=0, rdata=0.
REQ-015 Data SHALL be right-justified: byte at addr maps to rdata[7:0]/wdata[7:0].
REQ-016 Reads SHALL zero-extend to dlen; asize 0/1/2 = 1/2/4 bytes.
REQ-017 Word index SHALL be addr[awords+1:2]; higher address bits ignored (decoding belongs to the mux).
REQ-018 Writes SHALL update only the addressed byte lanes, committed on the WAIT->RESP or IDLE->RESP edge.
REQ-019 Misaligned access (addr mod 2^asize != 0) or asize=3 SHALL complete in RESP with error=1, rdata=`AXO_MEM_EALIGN, and no write.
REQ-020 re and we both high SHALL complete with error=1, rdata=`AXO_MEM_EINVAL, and no write.
REQ-021 If re and we are both low during WAIT (initiator abort), the FSM SHALL return to IDLE, perform no write and assert no ready.
REQ-022 Request inputs SHALL be ignored during WAIT and RESP except for the abort check.
REQ-023 re/we still high in the cycle after RESP SHALL be treated as a new request.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, counter=0, ready=0, error=0, rdata=0.
REQ-025 Reset mid-WAIT SHALL cancel the pending write; storage contents SHALL NOT be cleared by reset.

Configuration
REQ-026 With AXO_MEM_SRAM_WPROT_EN defined: a write sampled while wprot=1 SHALL complete with error=1, rdata=`AXO_MEM_EPROT, and no write; reads are unaffected.
REQ-027 Without AXO_MEM_SRAM_WPROT_EN: the wprot port is absent and all aligned writes succeed.

Structure
REQ-028 axo_mem_pkg SHALL hold the FSM state enum and the byte-lane mask function (asize, addr[1:0] -> 4-bit mask).
REQ-029 The error codes AXO_MEM_EALIGN, AXO_MEM_EINVAL and AXO_MEM_EPROT SHALL be added to axo_defines.sv alongside AXO_MEM_EMISSING.
REQ-030 Storage SHALL be a single sub-module axo_sram_bytewe (awords-deep, 4 byte write enables, synchronous write, asynchronous read).

Verification
REQ-031 latency=1: write asize=2, addr 0x10, wdata 0xDEADBEEF; then read addr 0x10 -> each ready 2 cycles after request, rdata 0xDEADBEEF, error=0.
REQ-032 Byte write 0x5A to addr 0x13, then word read of 0x10 -> 0x5AADBEEF; halfword read of 0x12 -> 0x00005AAD.
REQ-033 Halfword read at addr 0x11 -> ready=1, error=1, rdata=`AXO_MEM_EALIGN; word at 0x10 unchanged.
REQ-034 latency=3: write issued, re/we dropped after 1 cycle, then read back -> no ready during the abort, old data returned.
REQ-035 rst_n pulsed low during WAIT of a write -> ready=0 immediately; subsequent read returns pre-write data.
REQ-036 WPROT_EN build: wprot=1, write 0x1 to addr 0x20 -> error=1, rdata=`AXO_MEM_EPROT, readback unchanged.

Source files
------------

// File: rtl/axo_mem_pkg.sv
// axo_mem_pkg
// Types and helpers shared by the Axo memory responders.
//   mem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   lane_mask   : (asize, addr[1:0]) -> 4-bit byte-lane enable
//   misaligned  : (asize, addr[1:0]) -> 1 when the access cannot be served
//   size_mask   : asize -> mask that zero-extends a right-justified read
package axo_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Lanes are only meaningful for aligned accesses; asize=3 selects nothing
  // so an illegal size can never reach storage even if the error gate slips.
  function automatic logic [3:0] lane_mask(input logic [1:0] asize,
                                           input logic [1:0] lo);
    logic [3:0] m;
    case (asize)
      2'd0:    m = 4'b0001 << lo;
      2'd1:    m = 4'b0011 << lo;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] asize,
                                      input logic [1:0] lo);
    logic bad;
    case (asize)
      2'd0:    bad = 1'b0;
      2'd1:    bad = lo[0];
      2'd2:    bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] asize);
    logic [31:0] m;
    case (asize)
      2'd0:    m = 32'h0000_00FF;
      2'd1:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/axo_mem_bus.sv
// axo_mem_bus
// Axo memory bus: single outstanding request, held by the initiator until
// the responder pulses ready for one cycle.
//   re, we  : read / write request (level, held until ready)
//   addr    : byte address
//   asize   : log2 of access size in bytes (0=byte, 1=half, 2=word)
//   wdata   : right-justified write data
//   ready   : one-cycle completion strobe
//   error   : completion carries an error code on rdata
//   rdata   : right-justified, zero-extended read data or error code
// Modports: CPU = initiator end, MEM = responder end.
interface axo_mem_bus #(
  parameter int dlen = 32,
  parameter int alen = 32
);
  logic            re;
  logic            we;
  logic [alen-1:0] addr;
  logic [1:0]      asize;
  logic [dlen-1:0] wdata;
  logic            ready;
  logic            error;
  logic [dlen-1:0] rdata;

  modport CPU (
    output re, we, addr, asize, wdata,
    input  ready, error, rdata
  );

  modport MEM (
    input  re, we, addr, asize, wdata,
    output ready, error, rdata
  );
endinterface

// File: rtl/axo_defines.sv
// axo_defines.sv
// Shared macro definitions for the Axo memory bus.
// The AXO_MEM_E* values are the codes a responder places on rdata when it
// completes a transfer with error=1, so an initiator can tell why it failed.
`ifndef AXO_DEFINES_SV
`define AXO_DEFINES_SV

// No responder decoded the address.
`define AXO_MEM_EMISSING 32'hE000_0001
// Address not a multiple of the access size, or an unsupported size.
`define AXO_MEM_EALIGN   32'hE000_0002
// Read and write requested together.
`define AXO_MEM_EINVAL   32'hE000_0003
// Write refused because the region is write-protected.
`define AXO_MEM_EPROT    32'hE000_0004

`endif

// File: rtl/axo_sram_bytewe.sv
// axo_sram_bytewe
// Word-organised storage with per-byte write enables.
//   clk   : write clock
//   addr  : word index (2**awords words of 32 bits)
//   be    : byte write enables, be[i] writes wdata[8i+7:8i]
//   wdata : write data, already shifted onto its lanes
//   rdata : asynchronous read of the word at addr
// There is no reset: contents survive a reset of the surrounding logic.
module axo_sram_bytewe #(
  parameter int awords = 10
) (
  input  logic              clk,
  input  logic [awords-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<awords)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/axo_mem_sram.sv
// axo_mem_sram
// SRAM responder on the Axo memory bus with a fixed number of wait states.
// A request sampled in IDLE is captured, held for `latency` WAIT cycles and
// completed with a one-cycle ready in RESP. Misaligned, illegal-size and
// read+write requests complete with error=1 and an error code on rdata.
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset (storage is not cleared)
//   bus    : axo_mem_bus.MEM, responder end of the bus
//   wprot  : write-protect request, only with AXO_MEM_SRAM_WPROT_EN
// Parameters: dlen (32 only), alen, awords (log2 words), latency (0..15).
// Build option AXO_MEM_SRAM_WPROT_EN: adds wprot; a write sampled with
// wprot=1 completes with AXO_MEM_EPROT and leaves storage untouched.
`include "axo_defines.sv"

module axo_mem_sram #(
  parameter int dlen    = 32,
  parameter int alen    = 32,
  parameter int awords  = 10,
  parameter int latency = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  axo_mem_bus.MEM bus
`ifdef AXO_MEM_SRAM_WPROT_EN
  ,
  input  logic    wprot
`endif
);
  import axo_mem_pkg::*;

  // Byte-address bits that reach storage; the rest belong to the decoder.
  localparam int ibits = awords + 2;

  mem_state_e       state;
  logic [3:0]       wait_cnt;
  logic [ibits-1:0] cap_addr;
  logic [1:0]       cap_asize;
  logic [dlen-1:0]  cap_wdata;
  logic             cap_re;
  logic             cap_we;
`ifdef AXO_MEM_SRAM_WPROT_EN
  logic             cap_wprot;
`endif
  logic             ready_q;
  logic             error_q;
  logic [dlen-1:0]  rdata_q;

  logic             req_live;
  logic             in_idle;
  logic             go_resp;
  logic [ibits-1:0] eff_addr;
  logic [1:0]       eff_asize;
  logic [dlen-1:0]  eff_wdata;
  logic             eff_re;
  logic             eff_we;
`ifdef AXO_MEM_SRAM_WPROT_EN
  logic             eff_wprot;
`endif
  logic [1:0]       byte_off;
  logic             resp_err;
  logic [dlen-1:0]  resp_data;
  logic [dlen-1:0]  read_val;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[alen-1:ibits];
  assign req_live       = bus.re | bus.we;
  assign in_idle        = (state == IDLE);

  // With zero wait states the request completes on the edge it is sampled,
  // so the datapath works from the live bus in IDLE and from the captured
  // copy afterwards. One shared datapath serves both paths.
  assign eff_addr  = in_idle ? bus.addr[ibits-1:0] : cap_addr;
  assign eff_asize = in_idle ? bus.asize           : cap_asize;
  assign eff_wdata = in_idle ? bus.wdata           : cap_wdata;
  assign eff_re    = in_idle ? bus.re              : cap_re;
  assign eff_we    = in_idle ? bus.we              : cap_we;
`ifdef AXO_MEM_SRAM_WPROT_EN
  assign eff_wprot = in_idle ? wprot               : cap_wprot;
`endif

  assign byte_off  = eff_addr[1:0];
  assign read_val  = (mem_rdata >> {byte_off, 3'b000}) & size_mask(eff_asize);
  assign mem_wdata = eff_wdata << {byte_off, 3'b000};

  // Outcome of the pending request; an error suppresses the write entirely.
  always_comb begin
    resp_err  = 1'b0;
    resp_data = '0;
    if (eff_re && eff_we) begin
      resp_err  = 1'b1;
      resp_data = `AXO_MEM_EINVAL;
    end else if (misaligned(eff_asize, byte_off)) begin
      resp_err  = 1'b1;
      resp_data = `AXO_MEM_EALIGN;
`ifdef AXO_MEM_SRAM_WPROT_EN
    end else if (eff_we && eff_wprot) begin
      resp_err  = 1'b1;
      resp_data = `AXO_MEM_EPROT;
`endif
    end else if (eff_re) begin
      resp_data = read_val;
    end
  end

  // High in the cycle whose closing edge moves the FSM into RESP; that edge
  // also commits the write. An abort (re and we low) never gets here.
  always_comb begin
    go_resp = 1'b0;
    if (state == IDLE) begin
      go_resp = req_live && (latency == 0);
    end else if (state == WAIT) begin
      go_resp = req_live && (wait_cnt == 4'd0);
    end
  end

  // rst_n gates the strobe so a request held through reset cannot write.
  assign mem_be = (go_resp && rst_n && eff_we && !resp_err) ?
                  lane_mask(eff_asize, byte_off) : 4'b0000;

  axo_sram_bytewe #(
    .awords(awords)
  ) u_store (
    .clk  (clk),
    .addr (eff_addr[ibits-1:2]),
    .be   (mem_be),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // Request FSM with registered bus outputs. WAIT lasts exactly `latency`
  // cycles: the counter is loaded with latency-1 and RESP follows the cycle
  // in which it reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      cap_addr  <= '0;
      cap_asize <= 2'd0;
      cap_wdata <= '0;
      cap_re    <= 1'b0;
      cap_we    <= 1'b0;
`ifdef AXO_MEM_SRAM_WPROT_EN
      cap_wprot <= 1'b0;
`endif
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_live) begin
            cap_addr  <= bus.addr[ibits-1:0];
            cap_asize <= bus.asize;
            cap_wdata <= bus.wdata;
            cap_re    <= bus.re;
            cap_we    <= bus.we;
`ifdef AXO_MEM_SRAM_WPROT_EN
            cap_wprot <= wprot;
`endif
            if (go_resp) begin
              state   <= RESP;
              ready_q <= 1'b1;
              error_q <= resp_err;
              rdata_q <= resp_data;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(latency - 1);
            end
          end
        end
        WAIT: begin
          if (!req_live) begin
            state <= IDLE;
          end else if (go_resp) begin
            state   <= RESP;
            ready_q <= 1'b1;
            error_q <= resp_err;
            rdata_q <= resp_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.error = error_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_axo_mem_sram.sv
// tb_axo_mem_sram
// Bench for axo_mem_sram: one instance with latency 1 (dut_a) and one with
// latency 3 (dut_b) share the stimulus signals; sel routes re/we to one of
// them. Expected responses come from a byte-array model and are queued; a
// monitor on the falling edge pops and compares whenever ready is seen.
`include "axo_defines.sv"

module tb_axo_mem_sram;

  localparam int lat_a     = 1;
  localparam int lat_b     = 3;
  localparam int mem_bytes = 4096;

  typedef struct {
    int          dut;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel   = 1'b0;
  logic        re    = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [1:0]  asize = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic        wprot = 1'b0;
  bit          mon_on = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [7:0]  model_mem [2][mem_bytes];

  axo_mem_bus #(.dlen(32), .alen(32)) bus_a ();
  axo_mem_bus #(.dlen(32), .alen(32)) bus_b ();

  assign bus_a.re    = re & ~sel;
  assign bus_a.we    = we & ~sel;
  assign bus_a.addr  = addr;
  assign bus_a.asize = asize;
  assign bus_a.wdata = wdata;
  assign bus_b.re    = re & sel;
  assign bus_b.we    = we & sel;
  assign bus_b.addr  = addr;
  assign bus_b.asize = asize;
  assign bus_b.wdata = wdata;

  axo_mem_sram #(.dlen(32), .alen(32), .awords(10), .latency(lat_a)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
`ifdef AXO_MEM_SRAM_WPROT_EN
    ,
    .wprot(wprot)
`endif
  );

  axo_mem_sram #(.dlen(32), .alen(32), .awords(10), .latency(lat_b)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
`ifdef AXO_MEM_SRAM_WPROT_EN
    ,
    .wprot(wprot)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic checkPort(input int d, input logic rdy, input logic err,
                           input logic [31:0] rd);
    exp_t e;
    if (rdy) begin
      if (sb.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL spurious_ready: dut %0d ready=1 with nothing outstanding, expected ready=0 (cycle %0d)", d, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_dut", d, e.dut);
        checkOutput("error", {31'b0, err}, {31'b0, e.err});
        checkOutput("rdata", rd, e.data);
        checkOutput("ready_cycle", cyc, e.due);
      end
    end else begin
      checkOutput("idle_error", {31'b0, err}, 32'h0);
      checkOutput("idle_rdata", rd, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      checkPort(0, bus_a.ready, bus_a.error, bus_a.rdata);
      checkPort(1, bus_b.ready, bus_b.error, bus_b.rdata);
    end
  end

  // Predicts the response from byte-level memory rules, queues it, then
  // holds the request until ready (bounded) and drops it.
  task automatic applyStimulus(input int d, input logic r, input logic w,
                               input logic [31:0] a, input logic [1:0] sz,
                               input logic [31:0] wd, input logic wp);
    exp_t e;
    int   n;
    bit   got;
    n      = 1 << sz;
    e.dut  = d;
    e.err  = 1'b1;
    e.data = 32'h0;
    if (r && w) begin
      e.data = `AXO_MEM_EINVAL;
    end else if (sz == 2'd3 || (a % n) != 0) begin
      e.data = `AXO_MEM_EALIGN;
`ifdef AXO_MEM_SRAM_WPROT_EN
    end else if (w && wp) begin
      e.data = `AXO_MEM_EPROT;
`endif
    end else begin
      e.err = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (w) model_mem[d][(a + i) % mem_bytes] = wd[8*i +: 8];
        else   e.data[8*i +: 8] = model_mem[d][(a + i) % mem_bytes];
      end
    end
    @(negedge clk);
    sel   = (d == 1);
    re    = r;
    we    = w;
    addr  = a;
    asize = sz;
    wdata = wd;
    wprot = wp;
    e.due = cyc + ((d == 1) ? lat_b : lat_a) + 1;
    sb.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = (d == 1) ? bus_b.ready : bus_a.ready;
    end
    re    = 1'b0;
    we    = 1'b0;
    wprot = 1'b0;
    if (!got) begin
      tests++;
      failures++;
      $display("[TB] FAIL timeout: dut %0d addr 0x%08h got no ready, expected ready within 40 cycles", d, a);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    #1;
    checkOutput("reset_ready_a", {31'b0, bus_a.ready}, 32'h0);
    checkOutput("reset_ready_b", {31'b0, bus_b.ready}, 32'h0);

    // Known contents for the 128-byte window the random phase uses.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 32; w++)
        applyStimulus(d, 1'b0, 1'b1, 32'(w * 4), 2'd2, $urandom, 1'b0);

    // Latency 1: word write/read, byte lane write, halfword read, errors.
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h13, 2'd0, 32'h1234565A, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h12, 2'd1, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h11, 2'd1, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'h10, 2'd2, 32'hFFFFFFFF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'hABCD_E010, 2'd2, 32'h0, 1'b0);

    // Latency 3: a write abandoned after one WAIT cycle must leave no trace.
    applyStimulus(1, 1'b0, 1'b1, 32'h10, 2'd2, 32'h11111111, 1'b0);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 32'h10; asize = 2'd2; wdata = 32'h22222222;
    @(negedge clk);
    we = 1'b0;
    repeat (6) @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);

    // Reset during WAIT of a write cancels it.
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 32'h10; asize = 2'd2; wdata = 32'h33333333;
    @(negedge clk);
    rst_n = 1'b0;
    we    = 1'b0;
    #1;
    checkOutput("reset_wait_ready", {31'b0, bus_b.ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Readback of old data; reset then lands while ready is high.
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_resp_ready", {31'b0, bus_b.ready}, 32'h0);
    checkOutput("reset_resp_rdata", bus_b.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 2'd2, 32'h0, 1'b0);

`ifdef AXO_MEM_SRAM_WPROT_EN
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 2'd2, 32'h1, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 2'd2, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 2'd2, 32'h0, 1'b0);
`endif

    // Random traffic inside the filled window, with random upper address
    // bits that must alias onto the same storage.
    for (int t = 0; t < 300; t++) begin
      int          d;
      int          kind;
      logic [1:0]  sz;
      logic [31:0] a;
      logic        wp;
      logic        aligned;
      d       = $urandom_range(0, 1);
      kind    = $urandom_range(0, 9);
      sz      = 2'($urandom_range(0, 3));
      a       = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      aligned = (sz != 2'd3) && ((a % (1 << sz)) == 0);
      wp      = ($urandom_range(0, 3) == 0);
      if (kind == 9) begin
        sz = 2'($urandom_range(0, 2));
        a  = a & ~((32'd1 << sz) - 32'd1);
        applyStimulus(d, 1'b1, 1'b1, a, sz, $urandom, 1'b0);
      end else if (kind < 5) begin
        applyStimulus(d, 1'b1, 1'b0, a, sz, 32'h0, wp);
      end else begin
        applyStimulus(d, 1'b0, 1'b1, a, sz, $urandom, wp && aligned);
      end
    end

    repeat (5) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
